// File: rtl/sa_host_pkg.sv
// Shared types and constants for the systolic-array host sequencer and the
// array wrapper it drives.
package sa_host_pkg;

  localparam int SA_N         = 4;
  localparam int N_ELEM       = SA_N * SA_N;
  localparam int IDX_W        = $clog2(N_ELEM);
  localparam int DEF_BITWIDTH = 4;
  localparam int DEF_OUTWIDTH = 8;
  localparam int DEF_TIMEOUT  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    STORE,
    WAIT_RES,
    DONE
  } state_t;

endpackage

// File: rtl/sa_host_bank.sv
// Small register file: one synchronous write port, one combinational read
// port, whole array cleared by reset.
module sa_host_bank #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage is built from flops, not a RAM macro, so it can take the
  // async clear; a RAM-inferred array would have to drop the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sa_host_sequencer.sv
// Host-side initiator for the systolic array nibble interface: streams the
// weight and input buffers, issues store, then collects the result bytes.
module sa_host_sequencer
  import sa_host_pkg::*;
#(
  parameter  int BITWIDTH = DEF_BITWIDTH,
  parameter  int OUTWIDTH = DEF_OUTWIDTH,
  parameter  int N        = SA_N,
  parameter  int TIMEOUT  = DEF_TIMEOUT,
  localparam int NE       = N * N,
  localparam int IW       = $clog2(NE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr_en,
  input  logic                cfg_wr_sel,
  input  logic [IW-1:0]       cfg_wr_addr,
  input  logic [BITWIDTH-1:0] cfg_wr_data,
  input  logic                start,
  input  logic                keep_weights,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [IW-1:0]       res_rd_addr,
  output logic [OUTWIDTH-1:0] res_rd_data,
  output logic [IW:0]         res_count,
  output logic [BITWIDTH-1:0] sa_data,
  output logic                sa_load_weights,
  output logic                sa_load_inputs,
  output logic                sa_store_outputs,
  input  logic [OUTWIDTH-1:0] sa_results,
  input  logic                sa_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state, state_d;
  logic [IW-1:0]       idx, idx_d;
  logic [IW:0]         cnt, cnt_d;
  logic [CW-1:0]       idle, idle_d;
  logic                err_q, err_d;
  logic                capture;
  logic                last_idx;
  logic [BITWIDTH-1:0] w_rd, i_rd;

  assign last_idx = (idx == IW'(NE - 1));
  // A beat in STORE counts too: the array is allowed to answer immediately.
  assign capture  = sa_valid && (state == STORE || state == WAIT_RES)
                    && (cnt < (IW+1)'(NE));

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    idle_d  = idle;
    err_d   = err_q;
    if (capture) cnt_d = cnt + 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = keep_weights ? LOAD_I : LOAD_W;
          idx_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_W: begin
        idx_d = idx + 1'b1;
        if (last_idx) begin
          idx_d   = '0;
          state_d = LOAD_I;
        end
      end
      LOAD_I: begin
        idx_d = idx + 1'b1;
        if (last_idx) begin
          idx_d   = '0;
          state_d = STORE;
        end
      end
      STORE: begin
        idle_d  = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (sa_valid) begin
          idle_d = '0;
          if (cnt == (IW+1)'(NE - 1)) state_d = DONE;
        end else if (idle == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          idle_d = idle + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      idle  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      idle  <= idle_d;
      err_q <= err_d;
    end
  end

  sa_host_bank #(.DEPTH(NE), .WIDTH(BITWIDTH)) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_wr_en && !busy && !cfg_wr_sel),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (idx),
    .rd_data (w_rd)
  );

  sa_host_bank #(.DEPTH(NE), .WIDTH(BITWIDTH)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_wr_en && !busy && cfg_wr_sel),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (idx),
    .rd_data (i_rd)
  );

  sa_host_bank #(.DEPTH(NE), .WIDTH(OUTWIDTH)) u_rbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_addr (cnt[IW-1:0]),
    .wr_data (sa_results),
    .rd_addr (res_rd_addr),
    .rd_data (res_rd_data)
  );

  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign err              = err_q;
  assign res_count        = cnt;
  assign sa_load_weights  = (state == LOAD_W);
  assign sa_load_inputs   = (state == LOAD_I);
  assign sa_store_outputs = (state == STORE);
  assign sa_data          = (state == LOAD_W) ? w_rd :
                            (state == LOAD_I) ? i_rd : '0;

endmodule

// File: tb/tb_sa_host_sequencer.sv
// Self-checking bench: table of jobs run against a cycle-accurate expectation,
// result beats tracked in a scoreboard queue, plus reset and idle corner cases.
module tb_sa_host_sequencer;

  localparam int NE = 16;
  localparam int TO = 64;

  logic       clk, rst_n;
  logic       cfg_wr_en, cfg_wr_sel;
  logic [3:0] cfg_wr_addr, cfg_wr_data;
  logic       start, keep_weights;
  logic       busy, done, err;
  logic [3:0] res_rd_addr;
  logic [7:0] res_rd_data;
  logic [4:0] res_count;
  logic [3:0] sa_data;
  logic       sa_load_weights, sa_load_inputs, sa_store_outputs;
  logic [7:0] sa_results;
  logic       sa_valid;

  sa_host_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_sel       (cfg_wr_sel),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_data      (cfg_wr_data),
    .start            (start),
    .keep_weights     (keep_weights),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .res_rd_addr      (res_rd_addr),
    .res_rd_data      (res_rd_data),
    .res_count        (res_count),
    .sa_data          (sa_data),
    .sa_load_weights  (sa_load_weights),
    .sa_load_inputs   (sa_load_inputs),
    .sa_store_outputs (sa_store_outputs),
    .sa_results       (sa_results),
    .sa_valid         (sa_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       keep;
    int         beats;
    logic       early;
    logic       hammer;
    logic       wr_start;
    logic [7:0] salt;
    int         exp_count;
    logic       exp_err;
  } job_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } beat_t;

  int         n_vec, n_err;
  logic [3:0] wmodel [NE];
  logic [3:0] imodel [NE];
  beat_t      sb [$];
  logic [7:0] exp_r0;
  job_t       jobs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic write_cfg(input logic sel, input int addr, input logic [3:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_sel  = sel;
    cfg_wr_addr = 4'(addr);
    cfg_wr_data = data;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    if (sel) imodel[addr] = data;
    else     wmodel[addr] = data;
  endtask

  // Runs one job from IDLE; per-cycle expectations derive from the cycle index.
  task automatic run_job(input job_t j);
    int off, s, first, d;
    logic [9:0] exp_v, got_v;
    logic       lw, li;
    logic [3:0] dexp;
    beat_t      b;
    off   = j.keep ? 0 : NE;
    s     = off + NE + 1;
    first = j.early ? s : s + 1;
    d     = (j.beats >= NE) ? first + NE : first + j.beats + TO;
    start = 1'b1;
    keep_weights = j.keep;
    if (j.wr_start) begin
      cfg_wr_en = 1'b1; cfg_wr_sel = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 4'h9;
      imodel[0] = 4'h9;
    end
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    sb.delete();
    for (int c = 1; c <= d + 1; c++) begin
      if (j.hammer && c <= d) begin
        start = 1'b1; cfg_wr_en = 1'b1; cfg_wr_sel = c[0];
        cfg_wr_addr = 4'(c); cfg_wr_data = 4'(c * 7);
      end else begin
        start = 1'b0; cfg_wr_en = 1'b0;
      end
      if (c >= first && c < first + j.beats) begin
        sa_valid   = 1'b1;
        sa_results = (8'hA0 + 8'(c - first)) ^ j.salt;
        if (c - first < NE) begin
          b.addr = 4'(c - first);
          b.data = sa_results;
          sb.push_back(b);
          if (c == first) exp_r0 = sa_results;
        end
      end else begin
        sa_valid   = 1'b0;
        sa_results = 8'h5A;
      end
      @(negedge clk);
      lw   = !j.keep && c <= NE;
      li   = c > off && c <= off + NE;
      dexp = lw ? wmodel[c-1] : li ? imodel[c-off-1] : 4'h0;
      exp_v = {c <= d, c == d, j.exp_err && c >= d, lw, li, c == s, dexp};
      got_v = {busy, done, err, sa_load_weights, sa_load_inputs, sa_store_outputs, sa_data};
      check($sformatf("stream c=%0d", c), 32'(got_v), 32'(exp_v));
      @(posedge clk); #1;
    end
    start = 1'b0; cfg_wr_en = 1'b0; sa_valid = 1'b0;
    check("res_count", 32'(res_count), 32'(j.exp_count));
    while (sb.size() > 0) begin
      b = sb.pop_front();
      res_rd_addr = b.addr;
      #1;
      check($sformatf("rbuf[%0d]", b.addr), 32'(res_rd_data), 32'(b.data));
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_r0 = 8'h00;
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_sel = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; keep_weights = 1'b0; res_rd_addr = 4'd3; sa_results = '0; sa_valid = 1'b0;
    for (int k = 0; k < NE; k++) begin wmodel[k] = '0; imodel[k] = '0; end

    //        keep  beats early hammer wr_st salt   count err
    jobs[0] = '{1'b0, 16,  1'b0, 1'b0, 1'b0, 8'h00, 16, 1'b0};
    jobs[1] = '{1'b1, 16,  1'b0, 1'b0, 1'b0, 8'h11, 16, 1'b0};
    jobs[2] = '{1'b0, 16,  1'b0, 1'b1, 1'b0, 8'h22, 16, 1'b0};
    jobs[3] = '{1'b0, 16,  1'b0, 1'b0, 1'b1, 8'h33, 16, 1'b0};
    jobs[4] = '{1'b0, 5,   1'b0, 1'b0, 1'b0, 8'h44, 5,  1'b1};
    jobs[5] = '{1'b0, 18,  1'b1, 1'b0, 1'b0, 8'h55, 16, 1'b0};

    #1;
    check("reset outputs",
          32'({busy, done, err, sa_load_weights, sa_load_inputs, sa_store_outputs, sa_data}), 32'd0);
    check("reset res_count", 32'(res_count), 32'd0);
    check("reset rbuf", 32'(res_rd_data), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NE; k++) write_cfg(1'b0, k, 4'(k));
    for (int k = 0; k < NE; k++) write_cfg(1'b1, k, 4'(15 - k));

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Beats while IDLE must not touch the result buffer, count or done.
    for (int c = 0; c < 5; c++) begin
      sa_valid = 1'b1; sa_results = 8'hFF;
      @(negedge clk);
      check("idle beat done/count", 32'({done, res_count}), 32'({1'b0, 5'd16}));
      @(posedge clk); #1;
    end
    sa_valid = 1'b0;
    res_rd_addr = 4'd0; #1;
    check("idle beat rbuf[0]", 32'(res_rd_data), 32'(exp_r0));

    // Reset asserted in LOAD_I, cycle 20 of a job.
    start = 1'b1; keep_weights = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("pre-reset load_inputs", 32'({sa_load_inputs, sa_data}), 32'({1'b1, imodel[3]}));
    #2 rst_n = 1'b0;
    #1;
    check("async reset drop",
          32'({busy, done, err, sa_load_weights, sa_load_inputs, sa_store_outputs, sa_data, res_count}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < NE; k++) begin wmodel[k] = '0; imodel[k] = '0; end
    for (int k = 0; k < NE; k += 5) begin
      res_rd_addr = 4'(k); #1;
      check($sformatf("rbuf[%0d] after reset", k), 32'(res_rd_data), 32'd0);
    end
    @(posedge clk); #1;
    run_job('{1'b1, 16, 1'b0, 1'b0, 1'b0, 8'h66, 16, 1'b0});
    for (int k = 0; k < NE; k++) write_cfg(1'b0, k, 4'(k ^ 5));
    for (int k = 0; k < NE; k++) write_cfg(1'b1, k, 4'(3 * k));
    run_job('{1'b0, 16, 1'b0, 1'b0, 1'b0, 8'h77, 16, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
